// File: rtl/midi_pkg.sv
// Shared MIDI definitions: byte classes, message kinds, event codes, parser states.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package midi_pkg;

    // Event type codes as presented on o_evt_type
    typedef enum logic [2:0] {
        EVT_NOTE_OFF = 3'd0,
        EVT_NOTE_ON  = 3'd1,
        EVT_CC       = 3'd2,
        EVT_PROG     = 3'd3,
        EVT_BEND     = 3'd4
    } evt_type_e;

    typedef enum logic [1:0] {
        BC_DATA   = 2'd0,   // 0x00-0x7F
        BC_CHAN   = 2'd1,   // 0x80-0xEF
        BC_SYSCOM = 2'd2,   // 0xF0-0xF7
        BC_RT     = 2'd3    // 0xF8-0xFF
    } byte_class_e;

    // Channel message kind is the status high nibble minus 8 (i.e. byte[6:4])
    typedef enum logic [2:0] {
        MK_NOTE_OFF = 3'd0,
        MK_NOTE_ON  = 3'd1,
        MK_POLY_AT  = 3'd2,
        MK_CC       = 3'd3,
        MK_PROG     = 3'd4,
        MK_CHAN_AT  = 3'd5,
        MK_BEND     = 3'd6,
        MK_NONE     = 3'd7
    } msg_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } state_e;

    localparam logic [7:0] DATA_MAX    = 8'h7F;
    localparam logic [7:0] CHAN_MAX    = 8'hEF;
    localparam logic [7:0] SYSCOM_MAX  = 8'hF7;
    localparam logic [7:0] SYSEX_START = 8'hF0;

    // Program change and channel pressure carry a single data byte
    function automatic logic is_two_byte(input msg_kind_e k);
        return (k != MK_PROG) && (k != MK_CHAN_AT);
    endfunction

endpackage

// File: rtl/midi_byte_class.sv
// Classifies a received MIDI byte and extracts the channel message kind.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
// Ports: i_byte  - byte under test
//        o_class - byte_class_e code (data / channel status / system common / realtime)
//        o_kind  - msg_kind_e code for channel status bytes, MK_NONE otherwise
module midi_byte_class
    import midi_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [1:0] o_class,
    output logic [2:0] o_kind
);

    always_comb begin
        o_class = BC_RT;
        o_kind  = MK_NONE;
        if (i_byte <= DATA_MAX) begin
            o_class = BC_DATA;
        end else if (i_byte <= CHAN_MAX) begin
            o_class = BC_CHAN;
            o_kind  = i_byte[6:4];
        end else if (i_byte <= SYSCOM_MAX) begin
            o_class = BC_SYSCOM;
        end
    end

endmodule

// File: rtl/midi_parser.sv
// MIDI byte-stream parser producing channel voice events with running status.
// Latency: event / error strobe one cycle after the strobe of the deciding byte.
// Backpressure: none; accepts one byte per cycle, back-to-back.
// Ports: i_clk, i_res_n (sync, active-low); i_rxFlg/i_rxData received byte strobe;
//        o_evt_valid + o_evt_type/ch/d1/d2 event (fields hold between events);
//        o_err protocol error strobe.
module midi_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_rxFlg,
    input  logic [7:0] i_rxData,
    output logic       o_evt_valid,
    output logic [2:0] o_evt_type,
    output logic [3:0] o_evt_ch,
    output logic [6:0] o_evt_d1,
    output logic [6:0] o_evt_d2,
    output logic       o_err
);

    state_e    r_state;
    msg_kind_e r_rs_kind;
    logic [3:0] r_rs_ch;
    logic [6:0] r_d1;
    logic       r_got_d1;     // a data byte arrived since the last status byte
    logic       r_evt_valid;
    logic [2:0] r_evt_type;
    logic [3:0] r_evt_ch;
    logic [6:0] r_evt_d1;
    logic [6:0] r_evt_d2;
    logic       r_err;

    logic [1:0] w_class;
    logic [2:0] w_kind;
    state_e     w_state_nxt;
    logic       w_rs_load;
    logic       w_rs_clear;
    logic       w_d1_latch;
    logic       w_err;
    logic       w_fire;
    evt_type_e  w_type;
    logic [6:0] w_d1;
    logic [6:0] w_d2;
    logic       w_incomplete;
    logic       w_ch_match;

    midi_byte_class u_class (
        .i_byte  (i_rxData),
        .o_class (w_class),
        .o_kind  (w_kind)
    );

    // A status byte cuts off a message only if data is still owed
    assign w_incomplete = (r_state == ST_WAIT_D2) || ((r_state == ST_WAIT_D1) && !r_got_d1);
    // Filtered messages are still parsed; only the event is suppressed
    assign w_ch_match   = OMNI || (r_rs_ch == CHANNEL);

    always_comb begin
        w_state_nxt = r_state;
        w_rs_load   = 1'b0;
        w_rs_clear  = 1'b0;
        w_d1_latch  = 1'b0;
        w_err       = 1'b0;
        w_fire      = 1'b0;
        w_type      = EVT_NOTE_OFF;
        w_d1        = r_d1;
        w_d2        = '0;
        if (i_rxFlg) begin
            case (byte_class_e'(w_class))
                BC_DATA: begin
                    case (r_state)
                        ST_IDLE: w_err = 1'b1;
                        ST_WAIT_D1: begin
                            w_d1_latch = 1'b1;
                            if (is_two_byte(r_rs_kind)) begin
                                w_state_nxt = ST_WAIT_D2;
                            end else if (r_rs_kind == MK_PROG) begin
                                w_fire = w_ch_match;
                                w_type = EVT_PROG;
                                w_d1   = i_rxData[6:0];
                            end
                        end
                        ST_WAIT_D2: begin
                            w_state_nxt = ST_WAIT_D1;
                            w_d2        = i_rxData[6:0];
                            case (r_rs_kind)
                                MK_NOTE_OFF: begin
                                    w_fire = w_ch_match;
                                    w_type = EVT_NOTE_OFF;
                                end
                                MK_NOTE_ON: begin
                                    w_fire = w_ch_match;
                                    // velocity 0 is the conventional note-off
                                    w_type = (i_rxData[6:0] == 7'd0) ? EVT_NOTE_OFF : EVT_NOTE_ON;
                                end
                                MK_CC: begin
                                    w_fire = w_ch_match;
                                    w_type = EVT_CC;
                                end
                                MK_BEND: begin
                                    w_fire = w_ch_match;
                                    w_type = EVT_BEND;
                                end
                                default: ; // poly pressure: parsed, no event
                            endcase
                        end
                        default: ; // SysEx payload is dropped
                    endcase
                end
                BC_CHAN: begin
                    w_err       = w_incomplete;
                    w_rs_load   = 1'b1;
                    w_state_nxt = ST_WAIT_D1;
                end
                BC_SYSCOM: begin
                    w_err       = w_incomplete;
                    w_rs_clear  = 1'b1;
                    w_state_nxt = (i_rxData == SYSEX_START) ? ST_SYSEX : ST_IDLE;
                end
                default: ; // realtime bytes are transparent
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            r_rs_kind   <= MK_NONE;
            r_rs_ch     <= '0;
            r_d1        <= '0;
            r_got_d1    <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_type  <= '0;
            r_evt_ch    <= '0;
            r_evt_d1    <= '0;
            r_evt_d2    <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_rs_load) begin
                r_rs_kind <= msg_kind_e'(w_kind);
                r_rs_ch   <= i_rxData[3:0];
                r_got_d1  <= 1'b0;
            end else if (w_rs_clear) begin
                r_rs_kind <= MK_NONE;
                r_rs_ch   <= '0;
                r_got_d1  <= 1'b0;
            end else if (w_d1_latch) begin
                r_got_d1  <= 1'b1;
            end
            if (w_d1_latch) begin
                r_d1 <= i_rxData[6:0];
            end
            r_evt_valid <= w_fire;
            r_err       <= w_err;
            if (w_fire) begin
                r_evt_type <= w_type;
                r_evt_ch   <= r_rs_ch;
                r_evt_d1   <= w_d1;
                r_evt_d2   <= w_d2;
            end
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_type  = r_evt_type;
    assign o_evt_ch    = r_evt_ch;
    assign o_evt_d1    = r_evt_d1;
    assign o_evt_d2    = r_evt_d2;
    assign o_err       = r_err;

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: three instances (omni, channel 5, channel 2)
// share one byte stream; outputs are sampled on the falling edge.
module tb_midi_parser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n;
    logic       rx_flg;
    logic [7:0] rx_dat;

    logic       a_v, a_e, b_v, b_e, c_v, c_e;
    logic [2:0] a_ty, b_ty, c_ty;
    logic [3:0] a_ch, b_ch, c_ch;
    logic [6:0] a_d1, a_d2, b_d1, b_d2, c_d1, c_d2;

    midi_parser u_omni (
        .i_clk(clk), .i_res_n(res_n), .i_rxFlg(rx_flg), .i_rxData(rx_dat),
        .o_evt_valid(a_v), .o_evt_type(a_ty), .o_evt_ch(a_ch),
        .o_evt_d1(a_d1), .o_evt_d2(a_d2), .o_err(a_e)
    );

    midi_parser #(.OMNI(1'b0), .CHANNEL(4'd5)) u_ch5 (
        .i_clk(clk), .i_res_n(res_n), .i_rxFlg(rx_flg), .i_rxData(rx_dat),
        .o_evt_valid(b_v), .o_evt_type(b_ty), .o_evt_ch(b_ch),
        .o_evt_d1(b_d1), .o_evt_d2(b_d2), .o_err(b_e)
    );

    midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) u_ch2 (
        .i_clk(clk), .i_res_n(res_n), .i_rxFlg(rx_flg), .i_rxData(rx_dat),
        .o_evt_valid(c_v), .o_evt_type(c_ty), .o_evt_ch(c_ch),
        .o_evt_d1(c_d1), .o_evt_d2(c_d2), .o_err(c_e)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] tx_q[$];
    logic       s_v[16], s_er[16], b5_v[16], b5_er[16], c2_v[16], c2_er[16];
    logic [2:0] s_ty[16], b5_ty[16];
    logic [3:0] s_ch[16], b5_ch[16];
    logic [6:0] s_d1[16], s_d2[16], b5_d1[16], b5_d2[16];

    // Outputs seen one cycle after byte k was strobed
    function automatic void sample(input int k);
        s_v[k]  = a_v;  s_er[k] = a_e;  s_ty[k] = a_ty; s_ch[k] = a_ch;
        s_d1[k] = a_d1; s_d2[k] = a_d2;
        b5_v[k] = b_v;  b5_er[k] = b_e; b5_ty[k] = b_ty; b5_ch[k] = b_ch;
        b5_d1[k] = b_d1; b5_d2[k] = b_d2;
        c2_v[k] = c_v;  c2_er[k] = c_e;
    endfunction

    // Bytes of tx_q go out on consecutive cycles with no gaps
    task automatic send_seq();
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge clk);
            if (i > 0) sample(i - 1);
            rx_flg = 1'b1;
            rx_dat = tx_q[i];
        end
        @(negedge clk);
        sample(tx_q.size() - 1);
        rx_flg = 1'b0;
        rx_dat = 8'h00;
    endtask

    function automatic int sum_v();
        int n = 0;
        for (int i = 0; i < tx_q.size(); i++) n += int'(s_v[i]);
        return n;
    endfunction

    function automatic int sum_er();
        int n = 0;
        for (int i = 0; i < tx_q.size(); i++) n += int'(s_er[i]);
        return n;
    endfunction

    function automatic int sum_c2();
        int n = 0;
        for (int i = 0; i < tx_q.size(); i++) n += int'(c2_v[i]) + int'(c2_er[i]);
        return n;
    endfunction

    function automatic int sum_b5v();
        int n = 0;
        for (int i = 0; i < tx_q.size(); i++) n += int'(b5_v[i]);
        return n;
    endfunction

    initial begin
        res_n  = 1'b0;
        rx_flg = 1'b0;
        rx_dat = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", a_v, 1'b0);
        check_eq("rst_err",   a_e, 1'b0);
        check_eq("rst_type",  a_ty, 3'd0);
        check_eq("rst_ch",    a_ch, 4'd0);
        check_eq("rst_d1",    a_d1, 7'd0);
        check_eq("rst_d2",    a_d2, 7'd0);
        res_n = 1'b1;
        @(negedge clk);

        // Basic note on, strobe lands exactly one cycle after third byte
        tx_q = '{8'h90, 8'h3C, 8'h64};
        send_seq();
        check_eq("on_v_early", {31'd0, s_v[0]} + {31'd0, s_v[1]}, 0);
        check_eq("on_valid", s_v[2], 1'b1);
        check_eq("on_type",  s_ty[2], 3'd1);
        check_eq("on_ch",    s_ch[2], 4'd0);
        check_eq("on_d1",    s_d1[2], 7'h3C);
        check_eq("on_d2",    s_d2[2], 7'h64);
        @(negedge clk);
        check_eq("on_one_cycle", a_v, 1'b0);

        // Running status, velocity-zero note on becomes note off
        tx_q = '{8'h93, 8'h40, 8'h50, 8'h42, 8'h00};
        send_seq();
        check_eq("rs_count", sum_v(), 2);
        check_eq("rs1_type", s_ty[2], 3'd1);
        check_eq("rs1_ch",   s_ch[2], 4'd3);
        check_eq("rs1_d1d2", {s_d1[2], s_d2[2]}, {7'h40, 7'h50});
        check_eq("rs2_valid", s_v[4], 1'b1);
        check_eq("rs2_type", s_ty[4], 3'd0);
        check_eq("rs2_d1d2", {s_d1[4], s_d2[4]}, {7'h42, 7'h00});
        check_eq("rs_err",   sum_er(), 0);

        // Realtime byte inside a pitch bend
        tx_q = '{8'hE1, 8'hF8, 8'h00, 8'h40};
        send_seq();
        check_eq("bend_valid", s_v[3], 1'b1);
        check_eq("bend_count", sum_v(), 1);
        check_eq("bend_type",  s_ty[3], 3'd4);
        check_eq("bend_ch",    s_ch[3], 4'd1);
        check_eq("bend_d1d2",  {s_d1[3], s_d2[3]}, {7'h00, 7'h40});
        tx_q = '{8'hF8};
        send_seq();
        check_eq("hold_valid", s_v[0], 1'b0);
        check_eq("hold_d2",    s_d2[0], 7'h40);
        check_eq("hold_type",  s_ty[0], 3'd4);

        // F6 drops to IDLE; stray data and truncated note both flag errors
        tx_q = '{8'hF6, 8'h3C, 8'h90, 8'h3C, 8'hB0, 8'h07, 8'h7F};
        send_seq();
        check_eq("err_f6",    s_er[0], 1'b0);
        check_eq("err_idle",  s_er[1], 1'b1);
        check_eq("err_trunc", s_er[4], 1'b1);
        check_eq("err_total", sum_er(), 2);
        check_eq("cc_count",  sum_v(), 1);
        check_eq("cc_valid",  s_v[6], 1'b1);
        check_eq("cc_fields", {s_ty[6], s_ch[6], s_d1[6], s_d2[6]}, {3'd2, 4'd0, 7'h07, 7'h7F});

        // SysEx skipped, program change filtered by channel
        tx_q = '{8'hF0, 8'h11, 8'h22, 8'hF7, 8'hC5, 8'h0A};
        send_seq();
        check_eq("sx_err",     sum_er(), 0);
        check_eq("prog5_valid", b5_v[5], 1'b1);
        check_eq("prog5_count", sum_b5v(), 1);
        check_eq("prog5_fields", {b5_ty[5], b5_ch[5], b5_d1[5], b5_d2[5]}, {3'd3, 4'd5, 7'h0A, 7'h00});
        check_eq("prog5_err",  {31'd0, b5_er[5]}, 0);
        check_eq("prog2_quiet", sum_c2(), 0);
        check_eq("prog_omni",  s_v[5], 1'b1);

        // Pressure messages are silent; running program change on channel 2
        tx_q = '{8'hA0, 8'h3C, 8'h40, 8'hD0, 8'h10, 8'hC2, 8'h0A, 8'h0B};
        send_seq();
        check_eq("press_count", sum_v(), 2);
        check_eq("press_err",   sum_er(), 0);
        check_eq("prog_rs_d1a", s_d1[6], 7'h0A);
        check_eq("prog_rs_d1b", {s_v[7], s_d1[7]}, {1'b1, 7'h0B});
        check_eq("prog2_hit",   {c2_v[6], c2_v[7]}, 2'b11);
        check_eq("prog5_miss",  sum_b5v(), 0);

        // Channel status ends SysEx without error
        tx_q = '{8'hF0, 8'h11, 8'h93, 8'h40, 8'h50};
        send_seq();
        check_eq("sxend_err", sum_er(), 0);
        check_eq("sxend_evt", {s_v[4], s_ty[4], s_ch[4]}, {1'b1, 3'd1, 4'd3});

        // Data after a non-SysEx system common byte is an error
        tx_q = '{8'hF1, 8'h05};
        send_seq();
        check_eq("f1_err", {s_er[0], s_er[1]}, 2'b01);

        // Status before first data byte is an error
        tx_q = '{8'h90, 8'h80};
        send_seq();
        check_eq("nodata_err", {s_er[0], s_er[1]}, 2'b01);

        // Reset in the middle of a message
        tx_q = '{8'h90, 8'h3C};
        send_seq();
        res_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_v",  a_v, 1'b0);
        check_eq("mid_rst_d1", a_d1, 7'd0);
        check_eq("mid_rst_ch", a_ch, 4'd0);
        res_n = 1'b1;
        tx_q = '{8'h64};
        send_seq();
        check_eq("post_rst_v",   s_v[0], 1'b0);
        check_eq("post_rst_err", s_er[0], 1'b1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
